// File: rtl/fp_divider_seq.sv
// fp_divider_seq: sequential IEEE-754 single-precision divider.
// Radix-2 restoring mantissa division, one quotient bit per clock,
// with a start/busy/done handshake. Subnormal inputs are flushed to zero.
// Optional build macro: FP_DIV_RNE_EN (round-to-nearest-even); when it is
// undefined the quotient is truncated (round toward zero).
module fp_divider_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIAS  = 127
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  output logic [EXP_W+MAN_W:0]     out,
  output logic                     busy,
  output logic                     done
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int QW = MAN_W + 4;          // hidden + mantissa + guard + round
  localparam int SW = MAN_W + 3;          // remainder width incl. sign bit
  localparam int EW = EXP_W + 2;          // signed exponent work width
  localparam int CW = $clog2(QW);

  localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
  localparam logic signed [EW-1:0] EMAX_E = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] ZERO_E = '0;
  localparam logic signed [EW-1:0] ONE_E  = EW'(1);
  localparam logic [CW-1:0]        CNT_INIT = CW'(QW - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DIV, NORM} state_t;

  state_t state_reg, state_next;

  logic [W-1:0]          a_reg, b_reg, out_reg;
  logic                  done_reg;
  logic                  sign_reg;
  logic signed [EW-1:0]  exp_reg;
  logic [SW-1:0]         rem_reg;
  logic [MAN_W:0]        mb_reg;
  logic [QW-1:0]         q_reg;
  logic [CW-1:0]         cnt_reg;

  // Operand field decode of the latched inputs
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic             res_sign;
  logic             special;
  logic [W-1:0]     special_val;

  assign ea = a_reg[W-2:MAN_W];
  assign eb = b_reg[W-2:MAN_W];
  assign fa = a_reg[MAN_W-1:0];
  assign fb = b_reg[MAN_W-1:0];
  assign res_sign = a_reg[W-1] ^ b_reg[W-1];

  // Classify operands and pick the result for the short special-case path
  always_comb begin
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == '1) && (fa == '0);
    b_inf  = (eb == '1) && (fb == '0);
    a_nan  = (ea == '1) && (fa != '0);
    b_nan  = (eb == '1) && (fb != '0);
    special     = 1'b1;
    special_val = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      special_val = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    end else if (b_zero || a_inf) begin
      special_val = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_zero || b_inf) begin
      special_val = {res_sign, {(W-1){1'b0}}};
    end else begin
      special = 1'b0;
    end
  end

  // One restoring step: trial subtract, keep it if non-negative
  logic [SW-1:0] diff;
  logic          q_bit;
  logic [SW-1:0] rem_sel;

  always_comb begin
    diff    = rem_reg - {2'b00, mb_reg};
    q_bit   = ~diff[SW-1];
    rem_sel = q_bit ? diff : rem_reg;
  end

  // Normalise, round and range-check the finished quotient
  logic                 hid, guard, rnd, sticky, round_up;
  logic [MAN_W-1:0]     man_t, man_f;
  logic [MAN_W:0]       man_r;
  logic signed [EW-1:0] exp_n, exp_r;
  logic [W-1:0]         norm_val;

  always_comb begin
    hid = q_reg[QW-1];
    if (hid) begin
      man_t = q_reg[QW-2:3];
      exp_n = exp_reg;
      guard = q_reg[2];
      rnd   = q_reg[1];
    end else begin
      man_t = q_reg[QW-3:2];
      exp_n = exp_reg - ONE_E;
      guard = q_reg[1];
      rnd   = q_reg[0];
    end
    // A quotient bit below the round position is still inexactness information
    sticky = (|rem_reg) | (hid & q_reg[0]);
`ifdef FP_DIV_RNE_EN
    round_up = guard & (rnd | sticky | man_t[0]);
`else
    // Truncation: rounding information is present but never applied
    round_up = 1'b0 & (guard | rnd | sticky);
`endif
    man_r = {1'b0, man_t} + {{MAN_W{1'b0}}, round_up};
    if (man_r[MAN_W]) begin
      exp_r = exp_n + ONE_E;
      man_f = '0;
    end else begin
      exp_r = exp_n;
      man_f = man_r[MAN_W-1:0];
    end
    if (exp_r >= EMAX_E) begin
      norm_val = {sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (exp_r <= ZERO_E) begin
      norm_val = {sign_reg, {(W-1){1'b0}}};
    end else begin
      norm_val = {sign_reg, exp_r[EXP_W-1:0], man_f};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = special ? IDLE : DIV;
      DIV:     if (cnt_reg == '0) state_next = NORM;
      NORM:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs derived from state
  always_comb begin
    busy = (state_reg != IDLE);
  end

  assign out  = out_reg;
  assign done = done_reg;

  // Operand latch, iterative datapath and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      out_reg  <= '0;
      done_reg <= 1'b0;
      sign_reg <= 1'b0;
      exp_reg  <= '0;
      rem_reg  <= '0;
      mb_reg   <= '0;
      q_reg    <= '0;
      cnt_reg  <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
          end
        end
        LOAD: begin
          if (special) begin
            out_reg  <= special_val;
            done_reg <= 1'b1;
          end else begin
            sign_reg <= res_sign;
            exp_reg  <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_E;
            rem_reg  <= {2'b00, 1'b1, fa};
            mb_reg   <= {1'b1, fb};
            q_reg    <= '0;
            cnt_reg  <= CNT_INIT;
          end
        end
        DIV: begin
          rem_reg <= rem_sel << 1;
          q_reg   <= {q_reg[QW-2:0], q_bit};
          cnt_reg <= cnt_reg - 1'b1;
        end
        NORM: begin
          out_reg  <= norm_val;
          done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_divider_seq.sv
// Self-checking bench for fp_divider_seq: vector table plus corner-case
// sequences (model-checked divide, ignored start, reset abort, reset+start).
module tb_fp_divider_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] out;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  fp_divider_seq dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .out  (out),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] expv;
    int          tol;
    string       name;
  } sb_t;

  sb_t sb[$];

  typedef struct {
    string       name;
    logic [31:0] av;
    logic [31:0] bv;
    logic [31:0] expv;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", name, act, req);
    end else begin
      $display("ok   %s: %08h", name, act);
    end
  endtask

  // Scoreboard: pop the oldest expectation whenever the DUT signals done
  always @(negedge clk) begin
    if (!rst && done) begin
      sb_t e;
      logic [31:0] d;
      bit match;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: out=%08h with no pending operation", out);
      end else begin
        e = sb.pop_front();
        if (e.tol == 0) begin
          match = (out === e.expv);
        end else begin
          d = (out > e.expv) ? out - e.expv : e.expv - out;
          match = (out[31:23] === e.expv[31:23]) && (d <= 32'(e.tol));
        end
        if (!match || busy) begin
          bad++;
          $display("FAIL %s: out=%08h busy=%0b want out=%08h(tol %0d) busy=0",
                   e.name, out, busy, e.expv, e.tol);
        end else begin
          $display("ok   %s: out=%08h", e.name, out);
        end
      end
    end
  end

  // Single-precision <-> real helpers for the reference model
  function automatic real f2r(input logic [31:0] x);
    real m;
    int  e;
    m = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f_trunc(input real v);
    logic s;
    int   e;
    int   man;
    s = (v < 0.0);
    if (s) v = -v;
    e = 127;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0)  begin v = v * 2.0; e--; end
    man = $rtoi((v - 1.0) * 8388608.0);
    return {s, e[7:0], man[22:0]};
  endfunction

  // Launch one divide, push its expectation, and check done latency.
  // With inject set, a conflicting start is pulsed mid-operation.
  task automatic run_op(input string name, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] expv, input int lat, input int tol, input bit inject);
    int cyc;
    bit seen;
    sb_t e;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    e.expv = expv; e.tol = tol; e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(posedge clk);
      cyc++;
      #1;
      if (done) seen = 1'b1;
      if (inject && cyc == 5) begin
        start = 1'b1; a = 32'h3F800000; b = 32'h00000000;
      end else if (inject && cyc == 6) begin
        start = 1'b0;
      end
    end
    chk({name, "_latency"}, 32'(seen ? cyc : -1), 32'(lat));
    if (!seen) sb.delete();
    @(negedge clk);
  endtask

  vec_t vecs[13];

  initial begin
    logic [31:0] ma, mb, mexp;
    int          cyc;
    bit          seen;

    vecs[0]  = '{"six_div_two",   32'h40C00000, 32'h40000000, 32'h40400000, 29};
`ifdef FP_DIV_RNE_EN
    vecs[1]  = '{"one_third",     32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 29};
`else
    vecs[1]  = '{"one_third",     32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 29};
`endif
    vecs[2]  = '{"one_div_zero",  32'h3F800000, 32'h00000000, 32'h7F800000, 1};
    vecs[3]  = '{"zero_div_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, 1};
    vecs[4]  = '{"overflow",      32'h7F000000, 32'h3E800000, 32'h7F800000, 29};
    vecs[5]  = '{"underflow",     32'h00800000, 32'h4B000000, 32'h00000000, 29};
    vecs[6]  = '{"nan_in",        32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1};
    vecs[7]  = '{"inf_div_inf",   32'h7F800000, 32'hFF800000, 32'h7FC00000, 1};
    vecs[8]  = '{"ninf_div_two",  32'hFF800000, 32'h40000000, 32'hFF800000, 1};
    vecs[9]  = '{"nzero_div_5",   32'h80000000, 32'h40A00000, 32'h80000000, 1};
    vecs[10] = '{"two_div_inf",   32'h40000000, 32'h7F800000, 32'h00000000, 1};
    vecs[11] = '{"m8_div_two",    32'hC1000000, 32'h40000000, 32'hC0800000, 29};
    vecs[12] = '{"eq_operands",   32'h3FC00000, 32'h3FC00000, 32'h3F800000, 29};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out", out, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_done", {31'b0, done}, 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].name, vecs[i].av, vecs[i].bv, vecs[i].expv, vecs[i].lat, 0, 1'b0);
    end

    // Result holds after done
    repeat (5) @(negedge clk);
    chk("out_held", out, 32'h3F800000);

    // General divide against a real-number reference, 1 ulp tolerance
    ma = 32'hC4823AE5;
    mb = 32'h431C3081;
    mexp = r2f_trunc(f2r(ma) / f2r(mb));
    run_op("model_div", ma, mb, mexp, 29, 1, 1'b0);
    chk("model_exp_field", {23'b0, out[31:23]}, 32'h00000181);

    // Start pulses while busy are ignored
    run_op("ignored_start", 32'h40C00000, 32'h40000000, 32'h40400000, 29, 0, 1'b1);

    // Reset at cycle 10 aborts the divide without a done pulse
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("abort_out", out, 32'h0);
    chk("abort_busy", {31'b0, busy}, 32'h0);
    seen = 1'b0;
    for (cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("abort_no_done", {31'b0, seen}, 32'h0);
    run_op("restart", 32'h40C00000, 32'h40000000, 32'h40400000, 29, 0, 1'b0);

    // start together with rst is dropped
    @(negedge clk);
    rst = 1'b1; start = 1'b1; a = 32'h40C00000; b = 32'h40000000;
    @(posedge clk);
    #1 chk("rst_start_busy0", {31'b0, busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(posedge clk);
    #1 chk("rst_start_busy1", {31'b0, busy}, 32'h0);
    repeat (35) @(negedge clk);
    chk("rst_start_out", out, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
